// File: rtl/pixel_write_master.sv
// Buffers pixel write requests in a small FIFO and issues each one as a single
// AXI4-Lite write, counting error responses and flagging the end of the frame.
`timescale 1ns/1ps
module pixel_write_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic                    req_last,
  output logic [ADDR_WIDTH-1:0]   oAWADDR,
  output logic [2:0]              oAWPROT,
  output logic                    oAWVALID,
  input  logic                    oAWREADY,
  output logic [DATA_WIDTH-1:0]   oWDATA,
  output logic [DATA_WIDTH/8-1:0] oWSTRB,
  output logic                    oWVALID,
  input  logic                    oWREADY,
  input  logic [1:0]              oBRESP,
  input  logic                    oBVALID,
  output logic                    oBREADY,
  output logic                    busy,
  output logic [7:0]              err_count,
  output logic                    RenderEndInterrupt,
  input  logic                    irq_clr
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic                  full, empty, push, pop, b_hs, last_pending;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign req_ready = !full && !ARESET;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && !empty;
  assign b_hs      = (state == RESP) && oBVALID && oBREADY;
  assign busy      = !empty || (state != IDLE);

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_addr[wr_ptr] <= req_addr;
      mem_data[wr_ptr] <= req_data;
      mem_last[wr_ptr] <= req_last;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state              <= IDLE;
      oAWADDR            <= '0;
      oAWPROT            <= '0;
      oAWVALID           <= 1'b0;
      oWDATA             <= '0;
      oWSTRB             <= '0;
      oWVALID            <= 1'b0;
      oBREADY            <= 1'b0;
      err_count          <= '0;
      RenderEndInterrupt <= 1'b0;
      last_pending       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            oAWADDR      <= mem_addr[rd_ptr];
            oWDATA       <= mem_data[rd_ptr];
            last_pending <= mem_last[rd_ptr];
            oAWPROT      <= 3'b010;
            oWSTRB       <= '1;
            oAWVALID     <= 1'b1;
            oWVALID      <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          if (oAWVALID && oAWREADY) oAWVALID <= 1'b0;
          if (oWVALID && oWREADY)   oWVALID  <= 1'b0;
          // Both channels either finished earlier or handshake on this edge.
          if ((!oAWVALID || oAWREADY) && (!oWVALID || oWREADY)) begin
            oBREADY <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          if (oBVALID) begin
            oBREADY <= 1'b0;
            if (oBRESP != 2'b00 && err_count != 8'hFF) err_count <= err_count + 8'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (b_hs && last_pending) RenderEndInterrupt <= 1'b1;
      else if (irq_clr)         RenderEndInterrupt <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pixel_write_master.sv
// Randomized bench for pixel_write_master: a queue-based reference model of the
// request stream, AXI write beats and response accounting, plus directed steps.
`timescale 1ns/1ps
module tb_pixel_write_master;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          req_last = 1'b0;
  logic [AW-1:0] oAWADDR;
  logic [2:0]    oAWPROT;
  logic          oAWVALID;
  logic          oAWREADY = 1'b0;
  logic [DW-1:0] oWDATA;
  logic [DW/8-1:0] oWSTRB;
  logic          oWVALID;
  logic          oWREADY = 1'b0;
  logic [1:0]    oBRESP = 2'b00;
  logic          oBVALID = 1'b0;
  logic          oBREADY;
  logic          busy;
  logic [7:0]    err_count;
  logic          RenderEndInterrupt;
  logic          irq_clr = 1'b0;

  pixel_write_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_last(req_last),
    .oAWADDR(oAWADDR), .oAWPROT(oAWPROT), .oAWVALID(oAWVALID), .oAWREADY(oAWREADY),
    .oWDATA(oWDATA), .oWSTRB(oWSTRB), .oWVALID(oWVALID), .oWREADY(oWREADY),
    .oBRESP(oBRESP), .oBVALID(oBVALID), .oBREADY(oBREADY),
    .busy(busy), .err_count(err_count), .RenderEndInterrupt(RenderEndInterrupt),
    .irq_clr(irq_clr)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } req_t;

  req_t exp_q[$];   // accepted, response not yet seen
  req_t dir_q[$];   // waiting to be offered
  int checks = 0;
  int errors = 0;
  int p_aw = 100, p_w = 100, p_b = 100, push_pct = 100, err_pct = 0, clr_pct = 0;
  bit clr_on_b = 1'b0;
  logic [7:0] exp_err = '0;
  logic exp_irq = 1'b0;
  bit aw_done = 1'b0, w_done = 1'b0;
  int n_push = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    req_t r;
    r.addr = a; r.data = d; r.last = l;
    return r;
  endfunction

  // One clock: check model state, drive the slave and request side at the
  // falling edge, then account for the handshakes the next rising edge takes.
  task automatic cycle();
    bit b_hs;
    @(negedge ACLK);
    chk("err_count", err_count, exp_err);
    chk("irq", RenderEndInterrupt, exp_irq);
    chk("busy", busy, exp_q.size() != 0);
    chk("aw_extra", oAWVALID && (exp_q.size() == 0 || aw_done), 0);
    chk("w_extra", oWVALID && (exp_q.size() == 0 || w_done), 0);
    chk("bready_early", oBREADY && !(aw_done && w_done), 0);

    oAWREADY = int'($urandom_range(99)) < p_aw;
    oWREADY  = int'($urandom_range(99)) < p_w;
    oBVALID  = oBREADY && (int'($urandom_range(99)) < p_b);
    oBRESP   = (int'($urandom_range(99)) < err_pct) ? 2'($urandom_range(3, 1)) : 2'b00;
    irq_clr  = clr_on_b ? oBVALID : (int'($urandom_range(99)) < clr_pct);
    if (dir_q.size() != 0 && int'($urandom_range(99)) < push_pct) begin
      req_valid = 1'b1;
      req_addr  = dir_q[0].addr;
      req_data  = dir_q[0].data;
      req_last  = dir_q[0].last;
    end else begin
      req_valid = 1'b0;
      req_addr  = AW'($urandom);
      req_data  = $urandom;
      req_last  = 1'($urandom);
    end

    if (oAWVALID && oAWREADY && exp_q.size() != 0 && !aw_done) begin
      chk("awaddr", oAWADDR, exp_q[0].addr);
      chk("awprot", oAWPROT, 3'b010);
      aw_done = 1'b1;
    end
    if (oWVALID && oWREADY && exp_q.size() != 0 && !w_done) begin
      chk("wdata", oWDATA, exp_q[0].data);
      chk("wstrb", oWSTRB, 4'hF);
      w_done = 1'b1;
    end
    b_hs = oBVALID && oBREADY;
    if (b_hs && exp_q.size() != 0) begin
      if (oBRESP != 2'b00 && exp_err != 8'd255) exp_err = exp_err + 8'd1;
      if (exp_q[0].last) exp_irq = 1'b1;
      else if (irq_clr)  exp_irq = 1'b0;
      void'(exp_q.pop_front());
      aw_done = 1'b0;
      w_done  = 1'b0;
    end else if (irq_clr) begin
      exp_irq = 1'b0;
    end
    if (req_valid && req_ready) begin
      exp_q.push_back(dir_q[0]);
      void'(dir_q.pop_front());
      n_push++;
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || dir_q.size() != 0) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_left", exp_q.size() + dir_q.size(), 0);
    cycle();
  endtask

  task automatic wait_awvalid(input int max);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!oAWVALID && n < max);
    chk("awvalid_wait", oAWVALID, 1);
  endtask

  initial begin
    int n0;
    logic [AW-1:0] a_skew;

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_awvalid", oAWVALID, 0);
    chk("rst_wvalid", oWVALID, 0);
    chk("rst_bready", oBREADY, 0);
    chk("rst_awaddr", oAWADDR, 0);
    chk("rst_wdata", oWDATA, 0);
    chk("rst_wstrb", oWSTRB, 0);
    chk("rst_awprot", oAWPROT, 0);
    chk("rst_err", err_count, 0);
    chk("rst_irq", RenderEndInterrupt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("req_ready_idle", req_ready, 1);

    // Single write with pop latency
    dir_q.push_back(mk(8'h05, 32'hDEADBEEF, 1'b0));
    cycle();
    cycle();
    chk("lat_awvalid_early", oAWVALID, 0);
    cycle();
    chk("lat_awvalid", oAWVALID, 1);
    chk("single_awaddr", oAWADDR, 8'h05);
    chk("single_wdata", oWDATA, 32'hDEADBEEF);
    chk("single_wstrb", oWSTRB, 4'hF);
    chk("single_awprot", oAWPROT, 3'b010);
    drain(50);
    chk("single_busy", busy, 0);

    // Skewed ready: W completes at once, AW stalled for three cycles
    p_aw = 0;
    a_skew = 8'h3C;
    dir_q.push_back(mk(a_skew, 32'h12345678, 1'b0));
    wait_awvalid(20);
    repeat (2) begin
      cycle();
      chk("skew_awvalid", oAWVALID, 1);
      chk("skew_awaddr", oAWADDR, a_skew);
      chk("skew_wvalid", oWVALID, 0);
      chk("skew_bready", oBREADY, 0);
    end
    p_aw = 100;
    cycle();
    chk("skew_awvalid_last", oAWVALID, 1);
    chk("skew_bready_last", oBREADY, 0);
    cycle();
    chk("skew_awvalid_drop", oAWVALID, 0);
    chk("skew_bready_rise", oBREADY, 1);
    drain(50);

    // FIFO full with AW stalled: four queued plus one in flight
    p_aw = 0;
    n0 = n_push;
    for (int i = 0; i < 6; i++) dir_q.push_back(mk(AW'(8'h40 + i), $urandom, 1'b0));
    repeat (10) cycle();
    chk("full_accepted", n_push - n0, 5);
    chk("full_ready", req_ready, 0);
    p_aw = 100;
    drain(200);

    // Error counting and saturation
    err_pct = 100;
    for (int i = 0; i < 3; i++) dir_q.push_back(mk(AW'($urandom), $urandom, 1'b0));
    drain(100);
    err_pct = 0;
    dir_q.push_back(mk(8'h77, $urandom, 1'b0));
    drain(50);
    chk("err3", err_count, 3);
    err_pct = 100;
    for (int i = 0; i < 257; i++) dir_q.push_back(mk(AW'($urandom), $urandom, 1'b0));
    drain(4000);
    chk("err_sat", err_count, 255);
    err_pct = 0;

    // Interrupt on last pixel; set beats a simultaneous clear
    dir_q.push_back(mk(8'h10, $urandom, 1'b0));
    dir_q.push_back(mk(8'h11, $urandom, 1'b1));
    drain(100);
    chk("irq_set", RenderEndInterrupt, 1);
    clr_on_b = 1'b1;
    dir_q.push_back(mk(8'h12, $urandom, 1'b1));
    drain(100);
    chk("irq_set_wins", RenderEndInterrupt, 1);
    clr_on_b = 1'b0;
    clr_pct = 100;
    repeat (2) cycle();
    chk("irq_cleared", RenderEndInterrupt, 0);
    clr_pct = 0;

    // Randomized traffic
    p_aw = 40; p_w = 40; p_b = 50; push_pct = 60; err_pct = 30; clr_pct = 10;
    for (int i = 0; i < 150; i++)
      dir_q.push_back(mk(AW'($urandom), $urandom, $urandom_range(7) == 0));
    drain(5000);
    p_aw = 100; p_w = 100; p_b = 100; push_pct = 100; err_pct = 0; clr_pct = 0;

    // Reset during SEND with entries queued
    p_aw = 0;
    for (int i = 0; i < 3; i++) dir_q.push_back(mk(AW'(8'hA0 + i), $urandom, 1'b1));
    wait_awvalid(20);
    repeat (2) cycle();
    @(negedge ACLK);
    ARESET = 1'b1;
    req_valid = 1'b0;
    oBVALID = 1'b0;
    irq_clr = 1'b0;
    @(posedge ACLK);
    #1;
    chk("mid_rst_awvalid", oAWVALID, 0);
    chk("mid_rst_wvalid", oWVALID, 0);
    chk("mid_rst_bready", oBREADY, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_irq", RenderEndInterrupt, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    exp_q.delete();
    dir_q.delete();
    exp_err = '0;
    exp_irq = 1'b0;
    aw_done = 1'b0;
    w_done = 1'b0;
    p_aw = 100;
    repeat (6) begin
      cycle();
      chk("post_rst_awvalid", oAWVALID, 0);
    end
    chk("post_rst_ready", req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
